// File: rtl/my_mem_arb_pkg.sv
// Shared types for the my_mem arbiter: FSM state encoding and the latched command record.
// The command fields are sized for the default my_mem geometry. The top-level width parameters must match it.
package my_mem_arb_pkg;

  localparam int CMD_ADDR_W = 16;
  localparam int CMD_DATA_W = 8;
  localparam int CMD_ID_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_ID_W-1:0]   id;
  } mem_cmd_t;

endpackage

// File: rtl/my_mem_arbiter_rr.sv
// Round-robin pick: the first asserted valid at or after ptr, searching circularly.
// Purely combinational. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Walk offsets from farthest to nearest so the nearest valid overwrites the rest.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/my_mem_arbiter.sv
// Shares one my_mem between NUM_REQ clients. It grants round-robin, issues one strobe per command,
// and returns read data tagged with the id of the requester.
module my_mem_arbiter
  import my_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W:0]              rsp_data,
  output logic                         mem_write,
  output logic                         mem_read,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_data_in,
  input  logic [DATA_W:0]              mem_data_out
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  mem_cmd_t         cmd_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [DATA_W:0]  rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The WAIT state spans RD_LAT cycles. Its last edge is the one that samples mem_data_out.
  wire wait_done = (state_q == WAIT) && (wait_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          state_d   = req_write[grant_idx] ? ISSUE_WR : ISSUE_RD;
        end
      end
      ISSUE_WR: begin
        // The strobes are keyed off the latched command, so they are exclusive by construction.
        mem_write   = cmd_q.write;
        mem_address = cmd_q.addr;
        mem_data_in = cmd_q.wdata;
        state_d     = IDLE;
      end
      ISSUE_RD: begin
        mem_read    = !cmd_q.write;
        mem_address = cmd_q.addr;
        state_d     = WAIT;
      end
      WAIT:    if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cmd_q      <= '0;
      wait_cnt_q <= '0;
      // NOTE: the response registers are reset so rsp_data/rsp_id read 0 until the first read returns.
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (state_q == IDLE && grant_any) begin
        cmd_q.write <= req_write[grant_idx];
        cmd_q.addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        cmd_q.wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
        cmd_q.id    <= grant_idx;
        ptr_q       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state_q == ISSUE_RD) begin
        wait_cnt_q <= CNT_W'(RD_LAT - 1);
      end else if (state_q == WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
      if (wait_done) begin
        rsp_data_q <= mem_data_out;
        rsp_id_q   <= cmd_q.id;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
